// File: rtl/rsa_pkg.sv
// rsa_pkg: definitions shared by the RSA encryption and decryption top levels.
//   RSA_WIDTH         operand width (128 only)
//   MUL_/DIV_ steps   per-core iteration counts; each step retires
//                     *_BITS_PER_STEP bits
//   MM_LATENCY        cycles from a modmul start pulse to its done pulse
//   state_t           3-bit top-level FSM encoding (IDLE..FIN)
//   msb_index()       priority encoder returning the highest set bit
package rsa_pkg;

  localparam int RSA_WIDTH = 128;

  localparam int MUL_BITS_PER_STEP = 8;
  localparam int MUL_STEPS         = RSA_WIDTH / MUL_BITS_PER_STEP;
  localparam int DIV_BITS_PER_STEP = 8;
  localparam int DIV_STEPS         = (2 * RSA_WIDTH) / DIV_BITS_PER_STEP;

  // start -> mul reset_n pulse -> MUL_STEPS -> done seen -> div reset_n
  // pulse -> DIV_STEPS -> done seen; independent of operand values.
  localparam int MM_LATENCY = MUL_STEPS + DIV_STEPS + 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_SQ    = 3'd2,
    ST_MUL   = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    MM_IDLE    = 3'd0,
    MM_MUL_RST = 3'd1,
    MM_MUL_RUN = 3'd2,
    MM_DIV_RST = 3'd3,
    MM_DIV_RUN = 3'd4
  } mm_phase_t;

  function automatic logic [6:0] msb_index(input logic [RSA_WIDTH-1:0] v);
    logic [6:0] idx;
    idx = '0;
    for (int k = 0; k < RSA_WIDTH; k++) begin
      if (v[k]) idx = 7'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// rsa_modmul: result = (a * b) mod n, one request at a time, fixed latency
// MM_LATENCY. Contains the two sequential cores it wraps.
//
// Handshake: start is a one-cycle request accepted only while the wrapper
// is idle; operands are captured on that cycle. done is a one-cycle pulse and
// result is valid only in that cycle. Each core is launched by holding its
// reset_n low for exactly one cycle and then waiting for its level done.
//
// Ports: clk, reset (sync, active-high; drops any in-flight request without
// pulsing the cores), start, a, b, n (128 b), result (128 b), done.

module SequentialMultiplier128Bit
  import rsa_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [RSA_WIDTH-1:0]     a,
  input  logic [RSA_WIDTH-1:0]     b,
  output logic [2*RSA_WIDTH-1:0]   product,
  output logic                     done
);
  localparam int CW = $clog2(MUL_STEPS + 1);
  localparam int PW = 2 * RSA_WIDTH;

  logic [PW-1:0]        mcand;
  logic [RSA_WIDTH-1:0] mplier;
  logic [CW-1:0]        cnt;

  // Shift-add, MUL_BITS_PER_STEP multiplier bits per cycle, LSB first.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      product <= '0;
      mcand   <= {{RSA_WIDTH{1'b0}}, a};
      mplier  <= b;
      cnt     <= '0;
    end else if (cnt != CW'(MUL_STEPS)) begin
      product <= product + mcand * {{(PW-MUL_BITS_PER_STEP){1'b0}},
                                    mplier[MUL_BITS_PER_STEP-1:0]};
      mcand   <= mcand << MUL_BITS_PER_STEP;
      mplier  <= mplier >> MUL_BITS_PER_STEP;
      cnt     <= cnt + CW'(1);
    end
  end

  assign done = (cnt == CW'(MUL_STEPS));
endmodule

module SequentialNonrestoringDivider256Bit
  import rsa_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2*RSA_WIDTH-1:0]   dividend,
  input  logic [RSA_WIDTH-1:0]     divisor,
  output logic [RSA_WIDTH-1:0]     remainder,
  output logic                     done
);
  localparam int CW = $clog2(DIV_STEPS + 1);
  localparam int DW = 2 * RSA_WIDTH;
  localparam int RW = RSA_WIDTH + 2;   // two's-complement partial remainder

  logic [DW-1:0] dvd, dvd_nxt;
  logic [RW-1:0] rem, rem_nxt, dvs;
  logic [CW-1:0] cnt;

  // The partial remainder stays in [-divisor, divisor), so RW bits hold
  // 2*rem + bit without overflow; bit RW-1 is the sign.
  always_comb begin
    rem_nxt = rem;
    dvd_nxt = dvd;
    for (int k = 0; k < DIV_BITS_PER_STEP; k++) begin
      if (rem_nxt[RW-1] == 1'b0)
        rem_nxt = {rem_nxt[RW-2:0], dvd_nxt[DW-1]} - dvs;
      else
        rem_nxt = {rem_nxt[RW-2:0], dvd_nxt[DW-1]} + dvs;
      dvd_nxt = {dvd_nxt[DW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem <= '0;
      dvd <= dividend;
      dvs <= {2'b00, divisor};
      cnt <= '0;
    end else if (cnt != CW'(DIV_STEPS)) begin
      rem <= rem_nxt;
      dvd <= dvd_nxt;
      cnt <= cnt + CW'(1);
    end
  end

  // Final correction of a negative remainder; the true remainder is < 2^128
  // so the low bits suffice.
  assign remainder = rem[RW-1] ? (rem[RSA_WIDTH-1:0] + dvs[RSA_WIDTH-1:0])
                               : rem[RSA_WIDTH-1:0];
  assign done      = (cnt == CW'(DIV_STEPS));
endmodule

module rsa_modmul
  import rsa_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [RSA_WIDTH-1:0] a,
  input  logic [RSA_WIDTH-1:0] b,
  input  logic [RSA_WIDTH-1:0] n,
  output logic [RSA_WIDTH-1:0] result,
  output logic                 done
);
  mm_phase_t phase, phase_nxt;

  logic [RSA_WIDTH-1:0]   a_r, b_r, n_r;
  logic [2*RSA_WIDTH-1:0] product;
  logic                   mul_done, div_done;
  logic                   mul_rst_n, div_rst_n;

  always_ff @(posedge clk) begin
    if (reset) phase <= MM_IDLE;
    else       phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    case (phase)
      MM_IDLE:    if (start) phase_nxt = MM_MUL_RST;
      MM_MUL_RST: phase_nxt = MM_MUL_RUN;
      MM_MUL_RUN: if (mul_done) phase_nxt = MM_DIV_RST;
      MM_DIV_RST: phase_nxt = MM_DIV_RUN;
      MM_DIV_RUN: if (div_done) phase_nxt = MM_IDLE;
      default:    phase_nxt = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
      n_r <= '0;
    end else if (phase == MM_IDLE && start) begin
      a_r <= a;
      b_r <= b;
      n_r <= n;
    end
  end

  // Cores see their start pulse only in the dedicated one-cycle phases; the
  // stale done of a previous run is never looked at because the run phase
  // begins after the core has reloaded.
  assign mul_rst_n = (phase != MM_MUL_RST);
  assign div_rst_n = (phase != MM_DIV_RST);

  SequentialMultiplier128Bit u_mul (
    .clk     (clk),
    .reset_n (mul_rst_n),
    .a       (a_r),
    .b       (b_r),
    .product (product),
    .done    (mul_done)
  );

  SequentialNonrestoringDivider256Bit u_div (
    .clk       (clk),
    .reset_n   (div_rst_n),
    .dividend  (product),
    .divisor   (n_r),
    .remainder (result),
    .done      (div_done)
  );

  assign done = (phase == MM_DIV_RUN) && div_done;
endmodule

// File: rtl/top_level_dec.sv
// top_level_dec: RSA decryption m = c^d mod n, 128-bit, MSB-first
// square-and-multiply using one shared rsa_modmul.
//
// Handshake: start is a one-cycle request taken only while busy=0; cipher,
// d_key and n are captured on that cycle. busy is high from the next cycle
// through the done cycle. done is a one-cycle pulse; m and error are valid
// in that cycle and m holds until the next result is written.
//
// Ports: clk, reset (sync, active-high), start, cipher, d_key, n (128 b),
//        m (128 b), done, busy, error, state (3 b debug view of the FSM).
//
// Build option TOP_LEVEL_DEC_LZ_SKIP_EN: CHECK priority-encodes the top set
// bit h of d, starts from acc=c at index h and skips the squarings of 1.
// Without it every one of the 128 bit positions is processed.

module top_level_dec
  import rsa_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [RSA_WIDTH-1:0] cipher,
  input  logic [RSA_WIDTH-1:0] d_key,
  input  logic [RSA_WIDTH-1:0] n,
  output logic [RSA_WIDTH-1:0] m,
  output logic                 done,
  output logic                 busy,
  output logic                 error,
  output logic [2:0]           state
);
  state_t cur, nxt;

  logic [RSA_WIDTH-1:0] c_r, d_r, n_r, acc;
  logic [6:0]           idx;
  logic                 issued;   // modmul request already sent in this step
  logic                 bad_operands;

  logic                 mm_start, mm_done;
  logic [RSA_WIDTH-1:0] mm_b, mm_result;

  assign bad_operands = (n_r == '0) || (c_r >= n_r);

  always_ff @(posedge clk) begin
    if (reset) cur <= ST_IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt      = cur;
    mm_start = 1'b0;
    mm_b     = acc;
    case (cur)
      ST_IDLE:  if (start) nxt = ST_CHECK;
      ST_CHECK: begin
        if (bad_operands || d_r == '0) nxt = ST_FIN;
        else begin
`ifdef TOP_LEVEL_DEC_LZ_SKIP_EN
          nxt = ST_NEXT;
`else
          nxt = ST_SQ;
`endif
        end
      end
      ST_SQ: begin
        mm_start = !issued;
        if (mm_done) nxt = d_r[idx] ? ST_MUL : ST_NEXT;
      end
      ST_MUL: begin
        mm_b     = c_r;
        mm_start = !issued;
        if (mm_done) nxt = ST_NEXT;
      end
      ST_NEXT:  nxt = (idx == 7'd0) ? ST_FIN : ST_SQ;
      ST_FIN:   nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  assign done  = (cur == ST_FIN);
  assign busy  = (cur != ST_IDLE);
  assign state = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      m      <= '0;
      error  <= 1'b0;
      c_r    <= '0;
      d_r    <= '0;
      n_r    <= '0;
      acc    <= '0;
      idx    <= '0;
      issued <= 1'b0;
    end else begin
      case (cur)
        ST_IDLE: begin
          if (start) begin
            c_r   <= cipher;
            d_r   <= d_key;
            n_r   <= n;
            error <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (bad_operands) begin
            error <= 1'b1;
            m     <= '0;
          end else if (d_r == '0) begin
            m <= (n_r == RSA_WIDTH'(1)) ? '0 : RSA_WIDTH'(1);
          end else begin
`ifdef TOP_LEVEL_DEC_LZ_SKIP_EN
            acc <= c_r;
            idx <= msb_index(d_r);
`else
            acc <= RSA_WIDTH'(1);
            idx <= 7'd127;
`endif
          end
        end
        ST_SQ, ST_MUL: begin
          if (mm_start) issued <= 1'b1;
          if (mm_done) begin
            acc    <= mm_result;
            issued <= 1'b0;
          end
        end
        ST_NEXT: begin
          if (idx == 7'd0) m   <= acc;
          else             idx <= idx - 7'd1;
        end
        default: ;
      endcase
    end
  end

  rsa_modmul u_modmul (
    .clk    (clk),
    .reset  (reset),
    .start  (mm_start),
    .a      (acc),
    .b      (mm_b),
    .n      (n_r),
    .result (mm_result),
    .done   (mm_done)
  );
endmodule

// File: tb/tb_top_level_dec.sv
// tb_top_level_dec: self-checking bench for top_level_dec. Expected results
// come from an LSB-first modular exponentiation on wide integers and the
// latency formula of the timing rules.
module tb_top_level_dec;
  import rsa_pkg::*;

  localparam int W = 128;
  localparam int L = MM_LATENCY;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] cipher, d_key, n, m;
  logic         done, busy, error;
  logic [2:0]   state;

  top_level_dec dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .cipher (cipher),
    .d_key  (d_key),
    .n      (n),
    .m      (m),
    .done   (done),
    .busy   (busy),
    .error  (error),
    .state  (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_mod_exp(input logic [W-1:0] c,
                                               input logic [W-1:0] d,
                                               input logic [W-1:0] nn);
    logic [2*W-1:0] r, base, modv;
    modv = {{W{1'b0}}, nn};
    r    = (2*W)'(1) % modv;
    base = {{W{1'b0}}, c};
    for (int k = 0; k < W; k++) begin
      if (d[k]) r = (r * base) % modv;
      base = (base * base) % modv;
    end
    return r[W-1:0];
  endfunction

  function automatic int ref_latency(input logic [W-1:0] c,
                                     input logic [W-1:0] d,
                                     input logic [W-1:0] nn);
    int pop, h;
    if (nn == 0 || c >= nn || d == 0) return 3;
    pop = $countones(d);
    h   = 0;
    for (int k = 0; k < W; k++) if (d[k]) h = k;
`ifdef TOP_LEVEL_DEC_LZ_SKIP_EN
    return 3 + (h + pop - 1) * (L + 1) + (h + 1);
`else
    return 3 + (W + pop) * (L + 1) + W;
`endif
  endfunction

  // ---------------- driver ----------------
  // poke=1 pulses start again mid-run with other operands; it must be ignored.
  task automatic run_op(input logic [W-1:0] c, input logic [W-1:0] d,
                        input logic [W-1:0] nn, input bit poke,
                        input string tag);
    int   edges, lat, limit, busy_low;
    logic want_err;
    want_err = (nn == 0) || (c >= nn);
    exp_q.push_back(want_err ? '0 : ref_mod_exp(c, d, nn));
    lat   = ref_latency(c, d, nn);
    limit = lat + 200;

    @(negedge clk);
    cipher = c; d_key = d; n = nn; start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start    = 1'b0;
    busy_low = 0;
    while (done !== 1'b1 && edges < limit) begin
      if (busy !== 1'b1) busy_low++;
      if (poke && edges == 4) begin
        start = 1'b1; cipher = 128'd5; d_key = 128'd1; n = 128'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start = 1'b0;

    if (done !== 1'b1) begin
      check({tag, "_timeout"}, 128'd0, 128'd1);
      void'(exp_q.pop_back());
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      return;
    end

    // The done cycle itself is the last cycle counted.
    check({tag, "_m"}, m, exp_q.pop_front());
    check({tag, "_error"}, W'(error), W'(want_err));
    check({tag, "_latency"}, W'(edges + 1), W'(lat));
    check({tag, "_busy_at_done"}, W'(busy), 128'd1);
    check({tag, "_busy_gaps"}, W'(busy_low), 128'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, W'(done), 128'd0);
    check({tag, "_busy_drop"}, W'(busy), 128'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] rc, rd, rn;
    int           waited, done_seen;

    reset = 1'b1; start = 1'b0; cipher = '0; d_key = '0; n = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m", m, '0);
    check("reset_done", W'(done), '0);
    check("reset_busy", W'(busy), '0);
    check("reset_error", W'(error), '0);
    check("reset_state", W'(state), W'(ST_IDLE));
    reset = 1'b0;

    run_op(128'd2790, 128'd2753, 128'd3233, 1'b0, "nominal");
    run_op(128'd1234, 128'd1,    128'd3233, 1'b0, "d_one");
    run_op(128'd0,    128'd0,    128'd1,    1'b0, "d0_n1");
    run_op(128'd5,    128'd7,    128'd0,    1'b0, "n_zero");
    run_op(128'd3233, 128'd2753, 128'd3233, 1'b0, "c_eq_n");
    run_op(128'd2790, 128'd0,    128'd3233, 1'b0, "d_zero_clears_err");
    run_op(128'd2790, 128'd2753, 128'd3233, 1'b1, "mid_start");

    // Reset while a squaring is in flight.
    @(negedge clk);
    cipher = 128'd2790; d_key = 128'd2753; n = 128'd3233; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    waited = 0;
    while (state !== 3'(ST_SQ) && waited < 20) begin
      @(posedge clk); @(negedge clk); waited++;
    end
    repeat (10) begin @(posedge clk); @(negedge clk); end
    check("rst_pre_state_sq", W'(state), W'(ST_SQ));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_m", m, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_state", W'(state), W'(ST_IDLE));
    done_seen = 0;
    repeat (L + 10) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("rst_no_stale_activity", W'(done_seen), '0);
    run_op(128'd2790, 128'd2753, 128'd3233, 1'b0, "after_reset");

    // Random valid operands with full-width modulus.
    for (int t = 0; t < 3; t++) begin
      rn = {$urandom, $urandom, $urandom, $urandom} | 128'd3;
      rc = {$urandom, $urandom, $urandom, $urandom} % rn;
      rd = W'($urandom) | 128'd1;
      run_op(rc, rd, rn, 1'b0, $sformatf("rand%0d", t));
    end

    // Random out-of-range ciphertext.
    rn = {1'b0, $urandom_range(32'h7fff_ffff, 1), 32'd0, $urandom, $urandom};
    rc = rn + W'($urandom_range(1000, 0));
    run_op(rc, 128'd3, rn, 1'b0, "rand_c_ge_n");

    check("queue_empty", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
